lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit controller between the execute stage and the data-memory bus. It accepts one load or store per transaction over a valid/ready handshake and issues a single bus request with decoupled request/response handshakes. It performs byte-lane alignment, mask generation, read-data extraction with sign/zero extension, and misalignment detection. It returns a one-cycle completion pulse with the result. It replaces the fixed-width single-handshake LSU and is parametrised in address/data width.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, bus data width; legal values are 32 and 64.
TIMEOUT_CYC, 255, maximum cycles spent in WAIT before an error is declared (used only with LSU_TIMEOUT_EN).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  execute-stage request valid
in_ready  out  1  LSU can accept a request
in_wen  in  1  1 = store, 0 = load
in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W=64)
in_signed  in  1  sign-extend the load result
in_addr  in  ADDR_W  byte address
in_wdata  in  DATA_W  store data, right-aligned
out_done  out  1  one-cycle completion pulse
out_rdata  out  DATA_W  extended load result (0 for stores)
out_err  out  1  completion carries an error
out_misalign  out  1  the error cause was misalignment
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts the request
bus_addr  out  ADDR_W  address aligned down to DATA_W/8 bytes
bus_wen  out  1  write request
bus_wdata  out  DATA_W  store data shifted into its byte lanes
bus_wmask  out  DATA_W/8  byte-enable mask
bus_resp_valid  in  1  response valid; the LSU is always ready to take it
bus_rdata  in  DATA_W  raw read data
bus_resp_err  in  1  bus error

Behaviour:
- Reset values: state=IDLE; in_ready=1; bus_req_valid=0; out_done=0; out_err=0; out_misalign=0; out_rdata=0; all captured registers 0.
- States: IDLE, REQ, WAIT, DONE. in_ready=1 only in IDLE.
- Accept: a request is accepted when in_valid && in_ready. On accept, capture wen, size, signed, addr[lowbits] and wdata.
- Misalignment is tested on accept. It is true when addr mod 2^size != 0, or when size=3 and DATA_W=32. On misalignment, go to DONE without any bus activity, with err=1 and misalign=1.
- Otherwise go to REQ and hold bus_req_valid=1 with all bus_* outputs stable until bus_req_ready. Then go to WAIT.
- bus_wen is meaningful only while bus_req_valid=1.
- Lanes: offset = addr mod (DATA_W/8). bus_wmask = ((1<<2^size)-1) << offset. bus_wdata = in_wdata << (8*offset). The mask is driven for loads too.
- WAIT: on bus_resp_valid, capture the response and go to DONE. err=bus_resp_err. For loads without error: out_rdata = (bus_rdata >> 8*offset), truncated to 2^size bytes, then sign- or zero-extended to DATA_W.
- A response arriving in the same cycle the request is accepted is not legal. It is ignored in REQ.
- DONE: out_done=1 for exactly one cycle and out_rdata/out_err/out_misalign are valid, then go to IDLE.
- A stream of accepts therefore gives at most one request per transaction. Minimum accept-to-done latency is 3 cycles (REQ, WAIT, DONE) with ready and response each arriving on the first possible cycle. Misaligned accept-to-done latency is 1 cycle.
- out_rdata, out_err and out_misalign hold their value after DONE until the next DONE.
- On a stores response, out_rdata=0.
- Reset mid-transaction (REQ or WAIT) abandons the transaction immediately: no out_done, and bus_req_valid drops on the next edge.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYC without bus_resp_valid, go to DONE with err=1, misalign=0, rdata=0. A late response is later ignored in IDLE.
- Not defined: WAIT lasts indefinitely and there is no counter logic.

Test Plan:
All scenarios use DATA_W=32.
- Signed byte load: addr=0x8000_0003, size=0, signed=1, bus_rdata=0x80AB_CDEF, ready and response immediate -> bus_addr=0x8000_0000, wmask=4'b1000, out_rdata=0xFFFF_FF80, out_done 3 cycles after accept, err=0.
- Unsigned half load: addr=0x8000_0002, size=1, signed=0, bus_rdata=0x80AB_CDEF -> wmask=4'b1100, out_rdata=0x0000_80AB.
- Half store: addr=0x8000_0002, size=1, wdata=0x0000_1234, bus_req_ready held low for 4 cycles -> bus_req_valid high for 5 cycles with bus_wdata=0x1234_0000, wmask=4'b1100, bus_wen=1 and outputs stable throughout; after the response, out_done=1 and out_rdata=0.
- Misaligned word load: addr=0x8000_0001, size=2 -> no bus_req_valid; out_done the cycle after accept with err=1 and misalign=1. Also size=3 -> same response.
- Bus error plus back-to-back requests: response with bus_resp_err=1 -> out_err=1 and misalign=0. in_valid held high -> the next accept occurs in the cycle after DONE.
- Reset and timeout: assert rst while in WAIT -> no out_done and in_ready=1 after the edge. With LSU_TIMEOUT_EN and TIMEOUT_CYC=8 and no response -> out_done with err=1 exactly 8 WAIT cycles after entering WAIT.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Execute-stage and data-memory-bus signal bundle for lsu_ctrl.
// master = the environment (execute stage plus memory), slave = the LSU itself.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Execute-stage request / completion
  logic                in_valid;
  logic                in_ready;
  logic                in_wen;
  logic [1:0]          in_size;
  logic                in_signed;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_wdata;
  logic                out_done;
  logic [DATA_W-1:0]   out_rdata;
  logic                out_err;
  logic                out_misalign;

  // Data-memory bus
  logic                bus_req_valid;
  logic                bus_req_ready;
  logic [ADDR_W-1:0]   bus_addr;
  logic                bus_wen;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_wmask;
  logic                bus_resp_valid;
  logic [DATA_W-1:0]   bus_rdata;
  logic                bus_resp_err;

  modport master (
    output in_valid, in_wen, in_size, in_signed, in_addr, in_wdata,
    input  in_ready, out_done, out_rdata, out_err, out_misalign,
    input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
    output bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
  );

  modport slave (
    input  in_valid, in_wen, in_size, in_signed, in_addr, in_wdata,
    output in_ready, out_done, out_rdata, out_err, out_misalign,
    output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
    input  bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one aligned bus request per accepted load/store.
// Optional WAIT timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave lsu
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("lsu_ctrl: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("lsu_ctrl: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state;
  logic                in_ready_q;
  logic                bus_req_valid_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [STRB_W-1:0]   bus_wmask_q;
  logic                out_done_q;
  logic [DATA_W-1:0]   out_rdata_q;
  logic                out_err_q;
  logic                out_misalign_q;
  logic                wen_q;
  logic                signed_q;
  logic [1:0]          size_q;
  logic [OFF_W-1:0]    off_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0]    wait_cnt;
`endif

  logic                accept;
  logic [OFF_W-1:0]    in_off;
  logic                in_misalign;
  logic [7:0]          size_bytes;
  logic [STRB_W-1:0]   in_mask;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   rd_keep;
  logic                rd_sign;
  logic [DATA_W-1:0]   rd_ext;

  assign accept = lsu.in_valid && in_ready_q;
  assign in_off = lsu.in_addr[OFF_W-1:0];

  // Accept-side decode: natural-alignment check and byte-lane mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    in_misalign = 1'b0;
    size_bytes  = 8'hFF;
    case (lsu.in_size)
      2'd0: size_bytes = 8'h01;
      2'd1: begin size_bytes = 8'h03; in_misalign = lsu.in_addr[0];    end
      2'd2: begin size_bytes = 8'h0F; in_misalign = |lsu.in_addr[1:0]; end
      default: in_misalign = (DATA_W == 32) || (|lsu.in_addr[2:0]);
    endcase
    in_mask = STRB_W'(size_bytes) << in_off;
  end

  // Load extraction: shift the addressed lanes down, keep 2^size bytes, extend.
  always_comb begin
    rd_shift = lsu.bus_rdata >> {off_q, 3'b000};
    rd_keep  = '1;
    rd_sign  = rd_shift[DATA_W-1];
    case (size_q)
      2'd0: begin rd_keep = DATA_W'(8'hFF);         rd_sign = rd_shift[7];  end
      2'd1: begin rd_keep = DATA_W'(16'hFFFF);      rd_sign = rd_shift[15]; end
      2'd2: begin rd_keep = DATA_W'(32'hFFFF_FFFF); rd_sign = rd_shift[31]; end
      default: ;
    endcase
    rd_ext = (rd_shift & rd_keep) | ((signed_q && rd_sign) ? ~rd_keep : '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state           <= IDLE;
      in_ready_q      <= 1'b1;
      bus_req_valid_q <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_wmask_q     <= '0;
      out_done_q      <= 1'b0;
      out_rdata_q     <= '0;
      out_err_q       <= 1'b0;
      out_misalign_q  <= 1'b0;
      wen_q           <= 1'b0;
      signed_q        <= 1'b0;
      size_q          <= '0;
      off_q           <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt        <= '0;
`endif
    end else begin
      out_done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          wen_q      <= lsu.in_wen;
          size_q     <= lsu.in_size;
          signed_q   <= lsu.in_signed;
          off_q      <= in_off;
          in_ready_q <= 1'b0;
          if (in_misalign) begin
            state          <= DONE;
            out_done_q     <= 1'b1;
            out_err_q      <= 1'b1;
            out_misalign_q <= 1'b1;
            out_rdata_q    <= '0;
          end else begin
            state           <= REQ;
            bus_req_valid_q <= 1'b1;
            bus_addr_q      <= {lsu.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_wmask_q     <= in_mask;
            bus_wdata_q     <= lsu.in_wdata << {in_off, 3'b000};
          end
        end
        // Responses seen here cannot belong to this request and are dropped.
        REQ: if (lsu.bus_req_ready) begin
          bus_req_valid_q <= 1'b0;
          state           <= WAIT;
`ifdef LSU_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
        end
        WAIT: if (lsu.bus_resp_valid) begin
          state          <= DONE;
          out_done_q     <= 1'b1;
          out_err_q      <= lsu.bus_resp_err;
          out_misalign_q <= 1'b0;
          out_rdata_q    <= (wen_q || lsu.bus_resp_err) ? '0 : rd_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state          <= DONE;
          out_done_q     <= 1'b1;
          out_err_q      <= 1'b1;
          out_misalign_q <= 1'b0;
          out_rdata_q    <= '0;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
`endif
        DONE: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu.in_ready      = in_ready_q;
  assign lsu.bus_req_valid = bus_req_valid_q;
  assign lsu.bus_addr      = bus_addr_q;
  assign lsu.bus_wen       = wen_q;
  assign lsu.bus_wdata     = bus_wdata_q;
  assign lsu.bus_wmask     = bus_wmask_q;
  assign lsu.out_done      = out_done_q;
  assign lsu.out_rdata     = out_rdata_q;
  assign lsu.out_err       = out_err_q;
  assign lsu.out_misalign  = out_misalign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with DATA_W=32; the timeout test
// runs only when LSU_TIMEOUT_EN is defined.
module tb_lsu_ctrl;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lsu ();

  lsu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (lsu)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !lsu.in_ready; i++) tick();
  endtask

  // Runs one transaction; the bus grants after ready_dly REQ cycles and answers
  // in the first WAIT cycle. Returns in the DONE cycle (or on budget expiry).
  task automatic do_txn(input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input int ready_dly, input logic [DATA_W-1:0] rdata,
                        input logic rerr, input bit keep_valid,
                        output int wait_cyc, output int lat, output int req_cyc,
                        output logic [ADDR_W-1:0] obs_addr, output logic [3:0] obs_mask);
    bit granted, hs;
    lsu.in_wen = wen; lsu.in_size = size; lsu.in_signed = sgn;
    lsu.in_addr = addr; lsu.in_wdata = wdata; lsu.in_valid = 1'b1;
    lsu.bus_req_ready = 1'b0; lsu.bus_resp_valid = 1'b0;
    lsu.bus_rdata = rdata; lsu.bus_resp_err = rerr;
    obs_addr = '0; obs_mask = '0;
    wait_cyc = 0;
    while (!lsu.in_ready && wait_cyc < 20) begin tick(); wait_cyc++; end
    tick();
    lat = 1; req_cyc = 0; granted = 0;
    if (!keep_valid) lsu.in_valid = 1'b0;
    while (!lsu.out_done && lat < 60) begin
      hs = 0;
      if (lsu.bus_req_valid) begin
        if (req_cyc == 0) begin obs_addr = lsu.bus_addr; obs_mask = lsu.bus_wmask; end
        req_cyc++;
        lsu.bus_req_ready  = (req_cyc > ready_dly);
        lsu.bus_resp_valid = 1'b0;
        hs = lsu.bus_req_ready;
      end else begin
        lsu.bus_req_ready  = 1'b0;
        lsu.bus_resp_valid = granted;
      end
      tick();
      lat++;
      if (hs) granted = 1;
    end
    lsu.bus_req_ready = 1'b0; lsu.bus_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    lsu.in_valid = 0; lsu.in_wen = 0; lsu.in_size = 0; lsu.in_signed = 0;
    lsu.in_addr = '0; lsu.in_wdata = '0; lsu.bus_req_ready = 0;
    lsu.bus_resp_valid = 0; lsu.bus_rdata = '0; lsu.bus_resp_err = 0;
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({lsu.in_ready, lsu.bus_req_valid, lsu.out_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready/req/done=%b, expected 100",
               {lsu.in_ready, lsu.bus_req_valid, lsu.out_done});
    end
    n_tests++;
    if ({lsu.out_err, lsu.out_misalign, lsu.out_rdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_result: got err=%b mis=%b rdata=%h, expected 0 0 0",
               lsu.out_err, lsu.out_misalign, lsu.out_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_signed_byte_load();
    int w, lat, rc; logic [ADDR_W-1:0] a; logic [3:0] m;
    do_txn(1'b0, 2'd0, 1'b1, 32'h8000_0003, '0, 0, 32'h80AB_CDEF, 1'b0, 1'b0, w, lat, rc, a, m);
    n_tests++;
    if (a !== 32'h8000_0000 || m !== 4'b1000) begin
      n_fail++;
      $display("FAIL sbyte_bus: got addr=%h mask=%b, expected 80000000 1000", a, m);
    end
    n_tests++;
    if (lat !== 3 || rc !== 1) begin
      n_fail++;
      $display("FAIL sbyte_latency: got lat=%0d req_cycles=%0d, expected 3 1", lat, rc);
    end
    n_tests++;
    if ({lsu.out_done, lsu.out_err, lsu.out_misalign} !== 3'b100 || lsu.out_rdata !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL sbyte_result: got done/err/mis=%b rdata=%h, expected 100 ffffff80",
               {lsu.out_done, lsu.out_err, lsu.out_misalign}, lsu.out_rdata);
    end
    tick();
    n_tests++;
    if (lsu.out_done !== 1'b0 || lsu.out_rdata !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL sbyte_hold: got done=%b rdata=%h, expected 0 ffffff80", lsu.out_done, lsu.out_rdata);
    end
  endtask

  task automatic test_load_lanes();
    logic [1:0]        t_size [6] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic              t_sgn  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [ADDR_W-1:0] t_addr [6] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000,
                                      32'h8000_0000, 32'h8000_0002, 32'h8000_0004};
    logic [3:0]        t_mask [6] = '{4'b1100, 4'b0010, 4'b0001, 4'b0011, 4'b1100, 4'b1111};
    logic [DATA_W-1:0] t_exp  [6] = '{32'h0000_80AB, 32'hFFFF_FFCD, 32'h0000_00EF,
                                      32'hFFFF_CDEF, 32'hFFFF_80AB, 32'h80AB_CDEF};
    int w, lat, rc; logic [ADDR_W-1:0] a; logic [3:0] m;
    for (int i = 0; i < 6; i++) begin
      do_txn(1'b0, t_size[i], t_sgn[i], t_addr[i], '0, 0, 32'h80AB_CDEF, 1'b0, 1'b0, w, lat, rc, a, m);
      n_tests++;
      if (m !== t_mask[i] || a !== {t_addr[i][31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL lanes_bus[%0d]: got addr=%h mask=%b, expected %h %b",
                 i, a, m, {t_addr[i][31:2], 2'b00}, t_mask[i]);
      end
      n_tests++;
      if (lsu.out_done !== 1'b1 || lsu.out_err !== 1'b0 || lsu.out_rdata !== t_exp[i]) begin
        n_fail++;
        $display("FAIL lanes_rdata[%0d]: got done=%b err=%b rdata=%h, expected 1 0 %h",
                 i, lsu.out_done, lsu.out_err, lsu.out_rdata, t_exp[i]);
      end
    end
  endtask

  task automatic test_half_store();
    wait_ready();
    lsu.in_wen = 1'b1; lsu.in_size = 2'd1; lsu.in_signed = 1'b0;
    lsu.in_addr = 32'h8000_0002; lsu.in_wdata = 32'h0000_1234;
    lsu.in_valid = 1'b1; lsu.bus_req_ready = 1'b0;
    tick();
    lsu.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if ({lsu.bus_req_valid, lsu.bus_wen, lsu.bus_addr, lsu.bus_wdata, lsu.bus_wmask} !==
          {1'b1, 1'b1, 32'h8000_0000, 32'h1234_0000, 4'b1100}) begin
        n_fail++;
        $display("FAIL store_req[%0d]: got v=%b wen=%b addr=%h wdata=%h mask=%b, expected 1 1 80000000 12340000 1100",
                 c, lsu.bus_req_valid, lsu.bus_wen, lsu.bus_addr, lsu.bus_wdata, lsu.bus_wmask);
      end
      lsu.bus_req_ready = (c == 4);
      tick();
    end
    lsu.bus_req_ready = 1'b0;
    n_tests++;
    if (lsu.bus_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_req_drop: got bus_req_valid=%b, expected 0", lsu.bus_req_valid);
    end
    lsu.bus_resp_valid = 1'b1; lsu.bus_rdata = 32'hDEAD_BEEF; lsu.bus_resp_err = 1'b0;
    tick();
    lsu.bus_resp_valid = 1'b0;
    n_tests++;
    if (lsu.out_done !== 1'b1 || lsu.out_err !== 1'b0 || lsu.out_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL store_done: got done=%b err=%b rdata=%h, expected 1 0 00000000",
               lsu.out_done, lsu.out_err, lsu.out_rdata);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]        t_size [2] = '{2'd2, 2'd3};
    logic [ADDR_W-1:0] t_addr [2] = '{32'h8000_0001, 32'h8000_0000};
    int w, lat, rc; logic [ADDR_W-1:0] a; logic [3:0] m;
    for (int i = 0; i < 2; i++) begin
      do_txn(1'b0, t_size[i], 1'b0, t_addr[i], '0, 0, 32'h0, 1'b0, 1'b0, w, lat, rc, a, m);
      n_tests++;
      if (lat !== 1 || rc !== 0 || lsu.bus_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_bus[%0d]: got lat=%0d req_cycles=%0d req_valid=%b, expected 1 0 0",
                 i, lat, rc, lsu.bus_req_valid);
      end
      n_tests++;
      if ({lsu.out_done, lsu.out_err, lsu.out_misalign} !== 3'b111) begin
        n_fail++;
        $display("FAIL misalign_flags[%0d]: got done/err/mis=%b, expected 111",
                 i, {lsu.out_done, lsu.out_err, lsu.out_misalign});
      end
    end
  endtask

  task automatic test_back_to_back();
    int w, lat, rc; logic [ADDR_W-1:0] a; logic [3:0] m;
    do_txn(1'b0, 2'd2, 1'b0, 32'h1000_0004, '0, 0, 32'h55AA_55AA, 1'b1, 1'b1, w, lat, rc, a, m);
    n_tests++;
    if ({lsu.out_done, lsu.out_err, lsu.out_misalign} !== 3'b110 || lat !== 3) begin
      n_fail++;
      $display("FAIL buserr_flags: got done/err/mis=%b lat=%0d, expected 110 3",
               {lsu.out_done, lsu.out_err, lsu.out_misalign}, lat);
    end
    do_txn(1'b0, 2'd2, 1'b0, 32'h1000_0008, '0, 0, 32'h1234_5678, 1'b0, 1'b0, w, lat, rc, a, m);
    n_tests++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL b2b_accept: got %0d idle cycles before accept, expected 1", w);
    end
    n_tests++;
    if (lsu.out_err !== 1'b0 || lsu.out_rdata !== 32'h1234_5678 || rc !== 1) begin
      n_fail++;
      $display("FAIL b2b_result: got err=%b rdata=%h req_cycles=%0d, expected 0 12345678 1",
               lsu.out_err, lsu.out_rdata, rc);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    // Reset while waiting for the response
    wait_ready();
    lsu.in_wen = 1'b0; lsu.in_size = 2'd2; lsu.in_addr = 32'h2000_0000;
    lsu.in_valid = 1'b1; lsu.bus_req_ready = 1'b1;
    tick();
    lsu.in_valid = 1'b0;
    tick();
    lsu.bus_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (lsu.in_ready !== 1'b1 || lsu.out_done !== 1'b0 || lsu.bus_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait: got ready=%b done=%b req=%b, expected 1 0 0",
               lsu.in_ready, lsu.out_done, lsu.bus_req_valid);
    end
    // Reset while the request is still pending on the bus
    lsu.in_valid = 1'b1;
    tick();
    lsu.in_valid = 1'b0;
    n_tests++;
    if (lsu.bus_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req_setup: got bus_req_valid=%b, expected 1", lsu.bus_req_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (lsu.bus_req_valid !== 1'b0 || lsu.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req: got req=%b ready=%b, expected 0 1", lsu.bus_req_valid, lsu.in_ready);
    end
    // A stray response after the abandon must not complete anything
    saw_done = 0;
    lsu.bus_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (lsu.out_done) saw_done = 1;
    end
    lsu.bus_resp_valid = 1'b0;
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL rst_no_done: got out_done=1 after abandoned transaction, expected 0");
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    wait_ready();
    lsu.in_wen = 1'b0; lsu.in_size = 2'd2; lsu.in_addr = 32'h3000_0000;
    lsu.in_valid = 1'b1; lsu.bus_req_ready = 1'b1; lsu.bus_resp_valid = 1'b0;
    tick();
    lsu.in_valid = 1'b0;
    tick();
    lsu.bus_req_ready = 1'b0;
    w = 0;
    while (!lsu.out_done && w < 50) begin tick(); w++; end
    n_tests++;
    if (w !== TIMEOUT_CYC) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d WAIT cycles, expected %0d", w, TIMEOUT_CYC);
    end
    n_tests++;
    if ({lsu.out_done, lsu.out_err, lsu.out_misalign} !== 3'b110 || lsu.out_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_flags: got done/err/mis=%b rdata=%h, expected 110 00000000",
               {lsu.out_done, lsu.out_err, lsu.out_misalign}, lsu.out_rdata);
    end
    tick();
    lsu.bus_resp_valid = 1'b1;
    tick();
    lsu.bus_resp_valid = 1'b0;
    n_tests++;
    if (lsu.out_done !== 1'b0 || lsu.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_late_resp: got done=%b ready=%b, expected 0 1", lsu.out_done, lsu.in_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_signed_byte_load();
    test_load_lanes();
    test_half_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
